trng_word_collector: RTL and testbench

//  Consumer end of the TRNG serial bit stream. Gates the generator's enable and samples its registered

---
 rtl/trng_pkg.sv | 17 +
 rtl/trng_rep_health.sv | 44 ++++
 rtl/trng_word_collector.sv | 131 +++++++++++++
 tb/tb_trng_word_collector.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// Shared state encoding and default parameter values for the TRNG word collector.
package trng_pkg;

  localparam int DEF_WORD_W      = 32;
  localparam int DEF_WARMUP_BITS = 64;
  localparam int DEF_REP_LIMIT   = 32;
  localparam int DEF_DEBIAS      = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WARMUP  = 3'd1,
    ST_COLLECT = 3'd2,
    ST_HOLD    = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

endpackage

// File: rtl/trng_rep_health.sv
// Repetition-count health test on the raw TRNG bit stream; fail flags the edge whose
// sample completes a run of REP_LIMIT identical bits.
module trng_rep_health #(
  parameter int REP_LIMIT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic raw_bit,
  input  logic clear,
  output logic fail
);

  localparam int CW = $clog2(REP_LIMIT + 1);

  logic [CW-1:0] run_cnt;
  logic [CW-1:0] run_next;
  logic          prev_bit;

  // A zero count means no previous bit since reset or the last clear.
  always_comb begin
    run_next = run_cnt;
    if (run_cnt == '0 || raw_bit != prev_bit)
      run_next = CW'(1);
    else if (run_cnt != CW'(REP_LIMIT))
      run_next = run_cnt + CW'(1);
  end

  assign fail = sample_en && (run_next == CW'(REP_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt  <= '0;
      prev_bit <= 1'b0;
    end else if (clear) begin
      run_cnt  <= '0;
      prev_bit <= 1'b0;
    end else if (sample_en) begin
      run_cnt  <= run_next;
      prev_bit <= raw_bit;
    end
  end

endmodule

// File: rtl/trng_word_collector.sv
// Consumer side of the TRNG serial stream: warm-up discard, optional von Neumann debiasing,
// repetition health test and word packing toward a valid/ready sink.
//
//   state   | meaning
//   IDLE    | generator off, waiting for run
//   WARMUP  | generator on, raw bits discarded
//   COLLECT | generator on, accepted bits shifted into the word
//   HOLD    | word presented, waiting for handshake
//   FAULT   | health test tripped, sticky until clr
module trng_word_collector
  import trng_pkg::*;
#(
  parameter int WORD_W      = DEF_WORD_W,
  parameter int WARMUP_BITS = DEF_WARMUP_BITS,
  parameter int REP_LIMIT   = DEF_REP_LIMIT,
  parameter int DEBIAS      = DEF_DEBIAS
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              run,
  input  logic              rand_in,
  output logic              trng_en,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              health_fail
);

  localparam int BW = $clog2(WORD_W + 1);
  localparam int WW = $clog2(WARMUP_BITS + 1);

  state_t        state;
  state_t        state_next;
  logic          en_q;
  logic [WW-1:0] warm_cnt;
  logic [BW-1:0] bit_cnt;
  logic          pair_phase;
  logic          pair_first;
  logic          accept;
  logic          accept_bit;
  logic          word_done;
  logic          warm_done;
  logic          fail;
  logic          health_clear;

  assign trng_en     = (state == ST_WARMUP) || (state == ST_COLLECT);
  assign word_valid  = (state == ST_HOLD);
  assign health_fail = (state == ST_FAULT);

  // rand_in lags trng_en by one cycle, so en_q is the sample strobe.
  always_comb begin
    accept     = 1'b0;
    accept_bit = rand_in;
    if (en_q && state == ST_COLLECT) begin
      if (DEBIAS == 0) begin
        accept = 1'b1;
      end else if (pair_phase && (pair_first != rand_in)) begin
        accept     = 1'b1;
        accept_bit = pair_first;
      end
    end
  end

  assign word_done = accept && (bit_cnt == BW'(WORD_W - 1));
  assign warm_done = en_q && (state == ST_WARMUP) && (warm_cnt == WW'(WARMUP_BITS - 1));

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (run) state_next = ST_WARMUP;
      ST_WARMUP:  if (!run) state_next = ST_IDLE;
                  else if (warm_done) state_next = ST_COLLECT;
      ST_COLLECT: if (!run) state_next = ST_IDLE;
                  else if (word_done) state_next = ST_HOLD;
      ST_HOLD:    if (word_ready) state_next = run ? ST_COLLECT : ST_IDLE;
      ST_FAULT:   state_next = ST_FAULT;
      default:    state_next = ST_IDLE;
    endcase
    if (fail) state_next = ST_FAULT;
  end

  assign health_clear = (state_next == ST_IDLE) && (state != ST_IDLE);

  trng_rep_health #(
    .REP_LIMIT (REP_LIMIT)
  ) u_health (
    .clk       (clk),
    .rst       (clr),
    .sample_en (en_q),
    .raw_bit   (rand_in),
    .clear     (health_clear),
    .fail      (fail)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= ST_IDLE;
      en_q       <= 1'b0;
      word_out   <= '0;
      warm_cnt   <= '0;
      bit_cnt    <= '0;
      pair_phase <= 1'b0;
      pair_first <= 1'b0;
    end else begin
      state <= state_next;
      en_q  <= trng_en;

      if (state == ST_IDLE)
        warm_cnt <= '0;
      else if (en_q && state == ST_WARMUP)
        warm_cnt <= warm_cnt + WW'(1);

      if (state_next == ST_IDLE || word_done)
        bit_cnt <= '0;
      else if (accept)
        bit_cnt <= bit_cnt + BW'(1);

      if (accept)
        word_out <= {word_out[WORD_W-2:0], accept_bit};

      // Pair alignment restarts every time collection (re)starts.
      if (state_next == ST_COLLECT && state != ST_COLLECT) begin
        pair_phase <= 1'b0;
      end else if (en_q && state == ST_COLLECT) begin
        pair_phase <= ~pair_phase;
        if (!pair_phase) pair_first <= rand_in;
      end
    end
  end

endmodule

// File: tb/tb_trng_word_collector.sv
// Directed-plus-random bench for trng_word_collector (WORD_W=8, WARMUP_BITS=4, REP_LIMIT=8),
// one instance per debias setting, expectations derived from the stream rules.
module tb_trng_word_collector;

  logic       clk = 1'b0;
  logic       clr;
  logic       run0, rand0, ready0, en0, valid0, hf0;
  logic [7:0] word0;
  logic       run1, rand1, ready1, en1, valid1, hf1;
  logic [7:0] word1;

  int   n_assert = 0;
  int   n_fail   = 0;
  logic last_b;
  int   run_len;
  logic dir_bits[$];
  logic raw_q[$];
  logic acc_q[$];
  logic [7:0] exp_w;

  always #5 clk = ~clk;

  trng_word_collector #(.WORD_W(8), .WARMUP_BITS(4), .REP_LIMIT(8), .DEBIAS(0)) dut0 (
    .clk(clk), .clr(clr), .run(run0), .rand_in(rand0), .trng_en(en0), .word_out(word0),
    .word_valid(valid0), .word_ready(ready0), .health_fail(hf0));

  trng_word_collector #(.WORD_W(8), .WARMUP_BITS(4), .REP_LIMIT(8), .DEBIAS(1)) dut1 (
    .clk(clk), .clr(clr), .run(run1), .rand_in(rand1), .trng_en(en1), .word_out(word1),
    .word_valid(valid1), .word_ready(ready1), .health_fail(hf1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Random raw bits never repeat more than 3 times, so the health test stays quiet.
  function automatic logic rb();
    if (run_len >= 3) return ~last_b;
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic gen_upd(input logic b);
    if (b === last_b) run_len++;
    else begin
      last_b  = b;
      run_len = 1;
    end
  endtask

  task automatic feed0(input logic b);
    rand0 = b;
    gen_upd(b);
    @(posedge clk);
    #1;
  endtask

  task automatic feed1(input logic b);
    rand1 = b;
    gen_upd(b);
    @(posedge clk);
    #1;
  endtask

  // Eight consecutive sampled bits are packed, first one landing in the MSB.
  task automatic pack8_0(output logic [7:0] exp);
    logic b;
    exp = '0;
    for (int i = 0; i < 8; i++) begin
      b = (i < dir_bits.size()) ? dir_bits[i] : rb();
      exp = (exp << 1) | 8'(b);
      feed0(b);
      if (i == 6) chk("d0_valid_early", valid0, 0);
    end
    chk("d0_valid", valid0, 1);
    chk("d0_word", word0, exp);
    chk("d0_en_hold", en0, 0);
    chk("d0_hf", hf0, 0);
  endtask

  // Edge 0 samples run in IDLE, edge 1 arms the sample strobe, edges 2..5 are warm-up.
  task automatic start0(output logic [7:0] exp);
    run0 = 1'b1;
    feed0(rb());
    chk("d0_en_start", en0, 1);
    feed0(rb());
    repeat (4) feed0(rb());
    chk("d0_valid_warm", valid0, 0);
    pack8_0(exp);
  endtask

  task automatic hs0(input logic run_after);
    ready0 = 1'b1;
    run0   = run_after;
    feed0(rb());
    ready0 = 1'b0;
    chk("d0_hs_valid", valid0, 0);
    chk("d0_hs_en", en0, run_after);
  endtask

  // Von Neumann model: raw collect bits taken in pairs, unequal pair yields its first bit.
  task automatic collect1(output logic [7:0] exp);
    logic b;
    logic done;
    int   idx;
    raw_q.delete();
    done = 1'b0;
    idx  = 0;
    exp  = '0;
    while (!done && idx < 200) begin
      b = (idx < dir_bits.size()) ? dir_bits[idx] : rb();
      idx++;
      feed1(b);
      raw_q.push_back(b);
      acc_q.delete();
      for (int i = 0; i + 1 < raw_q.size(); i += 2)
        if (raw_q[i] != raw_q[i+1]) acc_q.push_back(raw_q[i]);
      done = (acc_q.size() >= 8);
      chk("d1_valid_track", valid1, done);
    end
    if (!done) chk("d1_timeout", valid1, 1);
    else begin
      for (int i = 0; i < 8; i++) exp = (exp << 1) | 8'(acc_q[i]);
      chk("d1_word", word1, exp);
      chk("d1_en_hold", en1, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1;
    run0 = 0; rand0 = 0; ready0 = 0;
    run1 = 0; rand1 = 0; ready1 = 0;
    last_b = 0; run_len = 0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;

    chk("rst_valid0", valid0, 0);
    chk("rst_word0", word0, 0);
    chk("rst_en0", en0, 0);
    chk("rst_hf0", hf0, 0);
    chk("rst_valid1", valid1, 0);
    chk("rst_en1", en1, 0);

    // Directed first word: warm-up 0101, then 10110010.
    run0 = 1'b1;
    feed0(0);
    chk("t1_en", en0, 1);
    feed0(1);
    feed0(0); feed0(1); feed0(0); feed0(1);
    dir_bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    pack8_0(exp_w);
    dir_bits.delete();
    chk("t1_word_b2", word0, 8'hB2);
    repeat (3) feed0(rb());
    chk("t1_hold_valid", valid0, 1);
    chk("t1_hold_word", word0, 8'hB2);

    // Random words back to back, no warm-up between them.
    for (int k = 0; k < 4; k++) begin
      hs0(1'b1);
      feed0(rb());
      pack8_0(exp_w);
      repeat ($urandom_range(0, 3)) begin
        feed0(rb());
        chk("t2_stable_valid", valid0, 1);
        chk("t2_stable_word", word0, exp_w);
      end
    end
    hs0(1'b0);
    repeat (2) feed0(rb());
    chk("t2_idle_en", en0, 0);

    // Partial word abandoned after 5 bits.
    run0 = 1'b1;
    feed0(rb()); feed0(rb());
    repeat (4) feed0(rb());
    repeat (5) feed0(rb());
    run0 = 1'b0;
    feed0(rb());
    chk("t6_en", en0, 0);
    chk("t6_valid", valid0, 0);
    repeat (2) feed0(rb());
    start0(exp_w);

    // Asynchronous clear mid-collection, then a full restart.
    hs0(1'b1);
    feed0(rb());
    repeat (3) feed0(rb());
    #2 clr = 1'b1;
    #1;
    chk("t5_en", en0, 0);
    chk("t5_word", word0, 0);
    chk("t5_valid", valid0, 0);
    chk("t5_hf", hf0, 0);
    #2 clr = 1'b0;
    start0(exp_w);

    // Fault on the word-completing edge: 0 sampled in HOLD, then eight packed 1s.
    feed0(0);
    ready0 = 1'b1;
    feed0(rb());
    ready0 = 1'b0;
    feed0(rb());
    for (int i = 0; i < 8; i++) begin
      feed0(1);
      if (i == 6) chk("t4_hf_early", hf0, 0);
    end
    chk("t4_hf", hf0, 1);
    chk("t4_valid", valid0, 0);
    chk("t4_en", en0, 0);
    run0 = 1'b0;
    repeat (3) feed0(rb());
    run0 = 1'b1;
    repeat (3) feed0(rb());
    chk("t4_sticky_hf", hf0, 1);
    chk("t4_sticky_en", en0, 0);
    clr = 1'b1;
    #1;
    chk("t4_clr_hf", hf0, 0);
    #1 clr = 1'b0;
    run0 = 1'b0;

    // Debiased instance: directed pairs, then random words.
    run1 = 1'b1;
    feed1(0); feed1(1);
    feed1(0); feed1(1); feed1(0); feed1(1);
    dir_bits = '{1'b0,1'b1, 1'b1,1'b0, 1'b0,1'b0, 1'b1,1'b0, 1'b1,1'b1,
                 1'b0,1'b1, 1'b1,1'b0, 1'b1,1'b0, 1'b0,1'b1, 1'b1,1'b0};
    collect1(exp_w);
    dir_bits.delete();
    for (int k = 0; k < 2; k++) begin
      ready1 = 1'b1;
      feed1(rb());
      ready1 = 1'b0;
      chk("d1_hs_valid", valid1, 0);
      chk("d1_hs_en", en1, 1);
      feed1(rb());
      collect1(exp_w);
    end
    ready1 = 1'b1;
    run1   = 1'b0;
    feed1(rb());
    ready1 = 1'b0;
    chk("d1_idle_en", en1, 0);
    repeat (2) feed1(rb());

    // Eight 1s spanning warm-up and collection trip the debiased instance.
    run1 = 1'b1;
    feed1(rb()); feed1(rb());
    feed1(0);
    for (int i = 0; i < 8; i++) begin
      feed1(1);
      if (i == 6) chk("d1_hf_early", hf1, 0);
    end
    chk("d1_hf", hf1, 1);
    chk("d1_en_fault", en1, 0);
    run1 = 1'b0;
    repeat (2) feed1(rb());
    run1 = 1'b1;
    repeat (2) feed1(rb());
    chk("d1_sticky_hf", hf1, 1);
    chk("d1_sticky_valid", valid1, 0);
    clr = 1'b1;
    #1;
    chk("d1_clr_hf", hf1, 0);
    chk("d1_clr_word", word1, 0);
    #1 clr = 1'b0;
    run1 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
